// File: rtl/accum8_ctrl_if.sv
// accum8_ctrl_if: bundle for the accumulator front-end.
// Carries the operand handshake, the adder connection (A/B/Cin out, S/Cout in)
// and the result handshake. The slave side is the accum8_ctrl block; the
// master side is whatever feeds operands, hosts the adder and takes results.
interface accum8_ctrl_if #(
    parameter int CNT_W = 4
);
    // Frame control and operand stream
    logic             start;
    logic             din_valid;
    logic [7:0]       din;
    logic             din_ready;

    // Connection to the external 8-bit ripple-carry adder
    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic             add_cin;
    logic [7:0]       add_s;
    logic             add_cout;

    // Result and status
    logic [7:0]       acc;
    logic [CNT_W-1:0] ovf_cnt;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    modport slave (
        input  start, din_valid, din, add_s, add_cout, result_ready,
        output din_ready, add_a, add_b, add_cin, acc, ovf_cnt, result_valid, busy
    );

    modport master (
        output start, din_valid, din, add_s, add_cout, result_ready,
        input  din_ready, add_a, add_b, add_cin, acc, ovf_cnt, result_valid, busy
    );
endinterface

// File: rtl/accum8_ctrl.sv
// accum8_ctrl: sequential front-end and result stage for an external 8-bit
// ripple-carry adder. Accepts N_OPS operand bytes per frame, feeds each one to
// the adder's A input with the running accumulator on B, registers the sum and
// counts carry-outs, then presents the final accumulator and carry count on a
// result handshake.
//
// Build option: define ACCUM8_SAT_EN to make the accumulator saturate at 8'hFF
// instead of wrapping modulo 256. Ports and timing are the same either way.
module accum8_ctrl #(
    parameter int N_OPS = 4,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    accum8_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Operand index of the final operand of a frame, in op_cnt's width
    localparam logic [7:0]       LAST_OP = 8'(N_OPS - 1);
    localparam logic [CNT_W-1:0] OVF_MAX = '1;
    localparam logic [7:0]       ACC_MAX = 8'hFF;

    state_t           state_reg;
    state_t           state_next;
    logic [7:0]       acc_reg;
    logic [7:0]       acc_next;
    logic [CNT_W-1:0] ovf_cnt_reg;
    logic [CNT_W-1:0] ovf_cnt_next;
    logic [7:0]       op_cnt_reg;
    logic [7:0]       op_cnt_next;

    logic             din_ready_next;
    logic             result_valid_next;
    logic             busy_next;

    logic             accept;
    logic             last_accept;
    logic             frame_start;
    logic [7:0]       sum_sel;

    // An operand is taken only while accumulating; din_ready is 1 exactly there
    assign accept      = (state_reg == ST_ACCUM) && bus.din_valid;
    assign last_accept = accept && (op_cnt_reg == LAST_OP);
    assign frame_start = (state_reg == ST_IDLE) && bus.start;

    // Value loaded into the accumulator on an accept
`ifdef ACCUM8_SAT_EN
    // Saturating: once a carry is seen (or acc already pinned) stay at 255
    assign sum_sel = (bus.add_cout || (acc_reg == ACC_MAX)) ? ACC_MAX : bus.add_s;
`else
    // Wrapping: the adder's 8-bit sum is the modulo-256 result
    assign sum_sel = bus.add_s;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next        = state_reg;
        din_ready_next    = 1'b0;
        result_valid_next = 1'b0;
        busy_next         = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (bus.start) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                din_ready_next = 1'b1;
                if (last_accept) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here; a new frame
                // needs start while in IDLE
                result_valid_next = 1'b1;
                if (bus.result_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: clear on frame start, update on each accept
    always_comb begin
        acc_next     = acc_reg;
        ovf_cnt_next = ovf_cnt_reg;
        op_cnt_next  = op_cnt_reg;
        if (frame_start) begin
            acc_next     = 8'd0;
            ovf_cnt_next = '0;
            op_cnt_next  = 8'd0;
        end else if (accept) begin
            acc_next    = sum_sel;
            op_cnt_next = op_cnt_reg + 8'd1;
            if (bus.add_cout && (ovf_cnt_reg != OVF_MAX)) begin
                ovf_cnt_next = ovf_cnt_reg + 1'b1;
            end
        end
    end

    // Datapath registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= 8'd0;
            ovf_cnt_reg <= '0;
            op_cnt_reg  <= 8'd0;
        end else begin
            acc_reg     <= acc_next;
            ovf_cnt_reg <= ovf_cnt_next;
            op_cnt_reg  <= op_cnt_next;
        end
    end

    // Adder hookup: operand on A, running accumulator on B, no carry-in
    assign bus.add_a   = bus.din;
    assign bus.add_b   = acc_reg;
    assign bus.add_cin = 1'b0;

    // Status and result outputs
    assign bus.acc          = acc_reg;
    assign bus.ovf_cnt      = ovf_cnt_reg;
    assign bus.din_ready    = din_ready_next;
    assign bus.result_valid = result_valid_next;
    assign bus.busy         = busy_next;

endmodule

// File: doc/accum8_ctrl.md
# accum8_ctrl

Sequential front-end and result stage for the 8-bit ripple-carry adder (`task3`). It accepts a frame of `N_OPS` byte operands over a valid/ready handshake and drives each one into the adder's A inputs, with the running accumulator on B. It registers the adder's sum and carry-out every accepted cycle. After the last operand it presents the final accumulator and overflow count on a result handshake.

## Interface
Parameters:
- `N_OPS`, default 4: operands per frame; legal range 1..255.
- `CNT_W`, default 4: width of the overflow counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a frame; honoured only in IDLE.
- `din_valid` input 1: operand present on `din`.
- `din` input 8: operand byte.
- `din_ready` output 1: block accepts an operand this cycle.
- `add_a` output 8: to adder A8..A1; equals `din`.
- `add_b` output 8: to adder B8..B1; equals `acc`.
- `add_cin` output 1: to adder Cin; constant 0.
- `add_s` input 8: from adder S8..S1.
- `add_cout` input 1: from adder Cout.
- `acc` output 8: accumulator register.
- `ovf_cnt` output CNT_W: number of accepted operands that produced `add_cout`=1 in this frame; saturates at all-ones.
- `result_valid` output 1: final result on `acc` and `ovf_cnt`.
- `result_ready` input 1: consumer takes the result.
- `busy` output 1: state is not IDLE.

## Operation
- States are IDLE, ACCUM and DONE. There is an 8-bit operand counter `op_cnt`.
- **Reset** forces the state to IDLE and clears `acc`, `ovf_cnt`, `op_cnt`, `din_ready`, `result_valid` and `busy` to 0.
- **IDLE**
  - `din_ready`=0.
  - `start`=1 moves to ACCUM and clears `acc`, `ovf_cnt` and `op_cnt`.
  - Operands offered in IDLE are ignored.
- **ACCUM**
  - `din_ready`=1.
  - On an accept (`din_valid`&&`din_ready`):
    - `acc`<=`add_s`.
    - `op_cnt`<=`op_cnt`+1.
    - If `add_cout`=1 and `ovf_cnt` is not all-ones, `ovf_cnt`<=`ovf_cnt`+1.
  - When the accept has `op_cnt`==`N_OPS`-1, move to DONE.
  - Cycles with `din_valid`=0 leave all state unchanged.
  - `start` is ignored.
- **DONE**
  - `result_valid`=1 and `din_ready`=0.
  - `acc` and `ovf_cnt` are held stable.
  - `result_ready`=1 returns the block to IDLE.
  - `start` asserted in the same cycle as `result_ready` is ignored; a new frame requires `start` in IDLE.
- **Arithmetic:** the sum is computed by the external adder, with `add_cin`=0. Without saturation the accumulator is the 8-bit modulo-256 sum of all operands.

## Timing
- The adder is combinational. `add_s` is sampled in the same cycle that `din` is presented, so there is no added wait state.
- Operand throughput is one per cycle while `din_valid` is held high.
- The first accept can occur one cycle after `start` is sampled.
- `result_valid` rises on the cycle after the edge that accepts the Nth operand.
  - A gap-free frame from `start` to `result_valid` takes `N_OPS`+1 cycles.
- `result_valid` falls, and `busy` falls, on the edge where `result_ready` is sampled high.
- `rst` has priority over all other inputs in every state. Reset mid-frame discards the partial sum, and no result is produced.

## Configuration
- Macro `ACCUM8_SAT_EN`.
- **Defined:** an accept with `add_cout`=1, or any accept while `acc`==8'hFF, loads `acc`<=8'hFF. The accumulator saturates and stays at 255 for the rest of the frame. `ovf_cnt` still counts carry events.
- **Undefined:** `acc` wraps modulo 256.
- Ports and timing are identical in both builds.

## Test plan
- **Basic frame:** reset, `N_OPS`=4, `start`, then operands 1,2,4,8 with no gaps. Required: `acc`=15, `ovf_cnt`=0, and `result_valid` high 5 cycles after `start`.
- **Overflow:** operands 200,100,0,0.
  - Required without the macro: `acc`=44, `ovf_cnt`=1.
  - Required with `ACCUM8_SAT_EN`: `acc`=255, `ovf_cnt`=1.
- **Gaps and backpressure:**
  - Operands 16,32,64,128 with `din_valid` low for 2 cycles between each. Required: `acc`=240.
  - Hold `result_ready` low 3 cycles. Required: `result_valid`, `acc` and `ovf_cnt` stay stable; IDLE is entered on the cycle after `result_ready`=1.
- **Ignored inputs:**
  - Pulse `start` during ACCUM. Required: no restart.
  - Assert `din_valid` with `din`=255 while in IDLE and in DONE. Required: `din_ready`=0 and `acc` unchanged.
- **Reset mid-frame:** after two operands 5,6, assert `rst` for 1 cycle. Required: next cycle has `acc`=0, `busy`=0, `result_valid`=0. Then run a fresh frame of 1,1,1,1. Required: `acc`=4.
- **Counter saturation:** `N_OPS`=20, `CNT_W`=4, all operands 255. Required: `ovf_cnt`=15, not wrapping to 0.
